// File: rtl/l1_port_arbiter_if.sv
// rtl/l1_port_arbiter_if.sv - L1 requester ports and shared memory channel bundle
interface l1_port_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 2
);
    localparam int ID_W = $clog2(NUM_PORTS);
    localparam int BE_W = DATA_W / 8;

    // requester side
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0]        req_rnw;
    logic [NUM_PORTS*LEN_W-1:0]  req_len;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS*BE_W-1:0]   req_be;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_data;
    logic                        rsp_last;
    logic                        protocol_err;

    // downstream memory channel
    logic                        mem_valid;
    logic                        mem_ready;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_rnw;
    logic [LEN_W-1:0]            mem_len;
    logic [DATA_W-1:0]           mem_wdata;
    logic [BE_W-1:0]             mem_be;
    logic [ID_W-1:0]             mem_id;
    logic                        mem_rvalid;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        mem_rlast;

    // arbiter side
    modport master (
        input  req_valid, req_addr, req_rnw, req_len, req_wdata, req_be,
        input  mem_ready, mem_rvalid, mem_rdata, mem_rlast,
        output req_ready, rsp_valid, rsp_data, rsp_last, protocol_err,
        output mem_valid, mem_addr, mem_rnw, mem_len, mem_wdata, mem_be, mem_id
    );

    // requesters plus memory side
    modport slave (
        output req_valid, req_addr, req_rnw, req_len, req_wdata, req_be,
        output mem_ready, mem_rvalid, mem_rdata, mem_rlast,
        input  req_ready, rsp_valid, rsp_data, rsp_last, protocol_err,
        input  mem_valid, mem_addr, mem_rnw, mem_len, mem_wdata, mem_be, mem_id
    );
endinterface

// File: rtl/l1_port_arbiter.sv
// rtl/l1_port_arbiter.sv - N-port L1 arbiter with registered output and in-order read routing
module l1_port_arbiter #(
    parameter int    NUM_PORTS       = 4,
    parameter int    ADDR_W          = 32,
    parameter int    DATA_W          = 32,
    parameter int    LEN_W           = 2,
    parameter string PRIORITY_MODE   = "ROUND_ROBIN",
    parameter int    MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    l1_port_arbiter_if.master       bus
);
    localparam int ID_W       = $clog2(NUM_PORTS);
    localparam int BE_W       = DATA_W / 8;
    localparam int PTR_W      = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W      = PTR_W + 1;
    localparam bit FIXED_MODE = (PRIORITY_MODE == "FIXED");

    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     rd_cnt;

    logic                 capture;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [NUM_PORTS-1:0] eligible;
    logic                 gnt_any;
    logic [ID_W-1:0]      gnt_idx;
    logic [NUM_PORTS-1:0] gnt_oh;

    logic [ADDR_W-1:0]    sel_addr;
    logic                 sel_rnw;
    logic [LEN_W-1:0]     sel_len;
    logic [DATA_W-1:0]    sel_wdata;
    logic [BE_W-1:0]      sel_be;

    // The output register can take a new request when empty or draining this cycle
    assign capture    = !bus.mem_valid || bus.mem_ready;
    assign fifo_full  = (rd_cnt == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (rd_cnt == '0);
    // Reads are masked while the tracker is full; writes never need a slot
    assign eligible   = bus.req_valid & (~bus.req_rnw | {NUM_PORTS{!fifo_full}});

    // Search from the base upward, then wrap to the ports below it
    always_comb begin
        int base;
        base    = FIXED_MODE ? 0 : int'(rr_ptr);
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!gnt_any && eligible[i] && (i >= base)) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!gnt_any && eligible[i]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
    end

    assign gnt_oh = gnt_any ? (NUM_PORTS'(1) << gnt_idx) : '0;

    // Mux the winning port's request fields
    always_comb begin
        sel_addr  = '0;
        sel_len   = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt_oh[i]) begin
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_len   = bus.req_len[i*LEN_W +: LEN_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                sel_be    = bus.req_be[i*BE_W +: BE_W];
            end
        end
    end

    assign sel_rnw       = |(gnt_oh & bus.req_rnw);
    assign bus.req_ready = (rst_n && capture) ? gnt_oh : '0;

    assign push = capture && gnt_any && sel_rnw;
    assign pop  = bus.mem_rvalid && bus.mem_rlast && !fifo_empty;

    // Returning data goes to the port at the head of the read tracker
    assign bus.rsp_valid = (rst_n && bus.mem_rvalid && !fifo_empty)
                         ? (NUM_PORTS'(1) << fifo_mem[rd_ptr]) : '0;
    assign bus.rsp_data  = bus.mem_rdata;
    assign bus.rsp_last  = bus.mem_rlast;

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_rnw   <= 1'b0;
            bus.mem_len   <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            bus.mem_id    <= '0;
            rr_ptr        <= '0;
        end else if (capture) begin
            bus.mem_valid <= gnt_any;
            if (gnt_any) begin
                bus.mem_addr  <= sel_addr;
                bus.mem_rnw   <= sel_rnw;
                bus.mem_len   <= sel_len;
                bus.mem_wdata <= sel_wdata;
                bus.mem_be    <= sel_be;
                bus.mem_id    <= gnt_idx;
                rr_ptr        <= (gnt_idx == ID_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // In-order read tracker; count uses registered value for the full check
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= gnt_idx;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            rd_cnt <= rd_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Sticky flag for read data that nobody asked for
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.protocol_err <= 1'b0;
        end else if (bus.mem_rvalid && fifo_empty) begin
            bus.protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_l1_port_arbiter.sv
// tb/tb_l1_port_arbiter.sv - scoreboard bench for l1_port_arbiter
module tb_l1_port_arbiter;
    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 2;
    localparam int MO = 4;

    localparam logic [3:0] FF_VALID [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                            4'b1001, 4'b0001, 4'b0001, 4'b0000};
    localparam logic [3:0] FF_RNW   [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                            4'b0001, 4'b0001, 4'b0001, 4'b0001};
    localparam logic       FF_RET   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam int         FF_GNT   [8] = '{0, 0, 0, 0, 3, -1, 0, -1};

    typedef struct {
        logic [1:0]  id;
        logic [31:0] addr;
        logic        rnw;
        logic [1:0]  len;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t rr_q[$];
    exp_t fx_q[$];
    exp_t e;

    always #5 clk = ~clk;

    l1_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) rr_bus ();
    l1_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) fx_bus ();

    l1_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW),
                      .PRIORITY_MODE("ROUND_ROBIN"), .MAX_OUTSTANDING(MO))
        u_rr (.clk(clk), .rst_n(rst_n), .bus(rr_bus.master));

    l1_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW),
                      .PRIORITY_MODE("FIXED"), .MAX_OUTSTANDING(MO))
        u_fx (.clk(clk), .rst_n(rst_n), .bus(fx_bus.master));

    function automatic logic [31:0] addr_of(input int p);
        return 32'h1000_0000 + 32'(p) * 32'h100;
    endfunction

    function automatic logic [31:0] wdata_of(input int p);
        return 32'hD000_0000 + 32'(p);
    endfunction

    function automatic logic [3:0] onehot(input int p);
        logic [3:0] r;
        r = '0;
        if (p >= 0) r[p] = 1'b1;
        return r;
    endfunction

    function automatic exp_t mk(input int p, input logic rnw, input logic [1:0] len);
        exp_t x;
        x.id = 2'(p); x.addr = addr_of(p); x.rnw = rnw; x.len = len; x.wdata = wdata_of(p);
        return x;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs;
        rr_bus.req_valid = '0; rr_bus.req_rnw = '0; rr_bus.req_len = '0; rr_bus.req_be = '1;
        fx_bus.req_valid = '0; fx_bus.req_rnw = '0; fx_bus.req_len = '0; fx_bus.req_be = '1;
        for (int i = 0; i < NP; i++) begin
            rr_bus.req_addr[i*AW +: AW]  = addr_of(i);
            rr_bus.req_wdata[i*DW +: DW] = wdata_of(i);
            fx_bus.req_addr[i*AW +: AW]  = addr_of(i);
            fx_bus.req_wdata[i*DW +: DW] = wdata_of(i);
        end
        rr_bus.mem_ready = 1'b0; rr_bus.mem_rvalid = 1'b0; rr_bus.mem_rdata = '0; rr_bus.mem_rlast = 1'b0;
        fx_bus.mem_ready = 1'b0; fx_bus.mem_rvalid = 1'b0; fx_bus.mem_rdata = '0; fx_bus.mem_rlast = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rr_bus.req_valid = 4'hF; rr_bus.req_rnw = 4'hF; rr_bus.mem_ready = 1'b1;
        rr_bus.mem_rvalid = 1'b1; rr_bus.mem_rlast = 1'b1;
        tick();
        checks++; if (rr_bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %0h expected 0", rr_bus.req_ready); end
        checks++; if (rr_bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0h expected 0", rr_bus.rsp_valid); end
        checks++; if (rr_bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %0h expected 0", rr_bus.mem_valid); end
        checks++; if (rr_bus.mem_id !== 2'd0 || rr_bus.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_fields: got id %0h addr %0h expected 0", rr_bus.mem_id, rr_bus.mem_addr); end
        checks++; if (rr_bus.protocol_err !== 1'b0) begin errors++; $display("FAIL reset_protocol_err: got %0h expected 0", rr_bus.protocol_err); end
        checks++; if (fx_bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_fx_mem_valid: got %0h expected 0", fx_bus.mem_valid); end
        rr_bus.req_valid = '0; rr_bus.req_rnw = '0; rr_bus.mem_rvalid = 1'b0; rr_bus.mem_rlast = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (rr_bus.mem_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %0h expected 0", rr_bus.mem_valid); end
    endtask

    task automatic test_rr_fairness;
        int rsp_cnt [NP];
        int exp_id;
        for (int i = 0; i < NP; i++) rsp_cnt[i] = 0;
        rr_bus.mem_ready = 1'b1;
        rr_bus.req_valid = 4'hF;
        rr_bus.req_rnw   = 4'hF;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) rr_bus.req_valid = '0;
            rr_bus.mem_rvalid = rr_bus.mem_valid && rr_bus.mem_rnw;
            rr_bus.mem_rlast  = rr_bus.mem_rvalid;
            rr_bus.mem_rdata  = 32'hA000_0000 + 32'(c);
            #1;
            if (c < 5) begin
                exp_id = c % NP;
                checks++; if (rr_bus.req_ready !== onehot(exp_id)) begin errors++; $display("FAIL rr_grant c%0d: got %0h expected %0h", c, rr_bus.req_ready, onehot(exp_id)); end
                rr_q.push_back(mk(exp_id, 1'b1, 2'd0));
            end
            if (rr_bus.mem_valid) begin
                if (rr_q.size() == 0) begin
                    checks++; errors++; $display("FAIL rr_unexpected_req: got id %0h expected none", rr_bus.mem_id);
                end else begin
                    e = rr_q.pop_front();
                    checks++; if (rr_bus.mem_id !== e.id || rr_bus.mem_addr !== e.addr) begin errors++; $display("FAIL rr_mem_req: got id %0h addr %0h expected id %0h addr %0h", rr_bus.mem_id, rr_bus.mem_addr, e.id, e.addr); end
                    checks++; if (rr_bus.rsp_valid !== onehot(int'(e.id))) begin errors++; $display("FAIL rr_rsp_valid: got %0h expected %0h", rr_bus.rsp_valid, onehot(int'(e.id))); end
                    else rsp_cnt[e.id]++;
                end
            end
            tick();
        end
        rr_bus.mem_rvalid = 1'b0; rr_bus.mem_rlast = 1'b0;
        for (int i = 0; i < NP; i++) begin
            checks++; if (rsp_cnt[i] != ((i == 0) ? 2 : 1)) begin errors++; $display("FAIL rr_rsp_count p%0d: got %0d expected %0d", i, rsp_cnt[i], (i == 0) ? 2 : 1); end
        end
        checks++; if (rr_q.size() != 0) begin errors++; $display("FAIL rr_queue_left: got %0d expected 0", rr_q.size()); end
    endtask

    task automatic test_fixed;
        int exp_id;
        fx_bus.mem_ready = 1'b1;
        fx_bus.req_rnw   = '0;
        for (int c = 0; c < 8; c++) begin
            fx_bus.req_valid = (c < 5) ? 4'b1010 : ((c < 7) ? 4'b1000 : 4'b0000);
            exp_id = (c < 5) ? 1 : ((c < 7) ? 3 : -1);
            #1;
            checks++; if (fx_bus.req_ready !== onehot(exp_id)) begin errors++; $display("FAIL fixed_grant c%0d: got %0h expected %0h", c, fx_bus.req_ready, onehot(exp_id)); end
            if (exp_id >= 0) fx_q.push_back(mk(exp_id, 1'b0, 2'd0));
            if (fx_bus.mem_valid) begin
                if (fx_q.size() == 0) begin
                    checks++; errors++; $display("FAIL fixed_unexpected_req: got id %0h expected none", fx_bus.mem_id);
                end else begin
                    e = fx_q.pop_front();
                    checks++; if (fx_bus.mem_id !== e.id || fx_bus.mem_wdata !== e.wdata) begin errors++; $display("FAIL fixed_mem_req: got id %0h wdata %0h expected id %0h wdata %0h", fx_bus.mem_id, fx_bus.mem_wdata, e.id, e.wdata); end
                end
            end
            tick();
        end
        checks++; if (fx_q.size() != 0 || fx_bus.mem_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain: got q %0d valid %0h expected 0 0", fx_q.size(), fx_bus.mem_valid); end
    endtask

    task automatic test_back_pressure;
        rr_bus.mem_ready = 1'b0;
        rr_bus.req_rnw   = '0;
        rr_bus.req_valid = 4'b0100;
        #1;
        checks++; if (rr_bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_first_grant: got %0h expected 4", rr_bus.req_ready); end
        rr_q.push_back(mk(2, 1'b0, 2'd0));
        tick();
        rr_bus.req_valid = 4'b0101;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (rr_bus.req_ready !== 4'b0) begin errors++; $display("FAIL bp_ready_held c%0d: got %0h expected 0", c, rr_bus.req_ready); end
            checks++; if (rr_bus.mem_valid !== 1'b1 || rr_bus.mem_id !== 2'd2 || rr_bus.mem_wdata !== wdata_of(2) || rr_bus.mem_addr !== addr_of(2)) begin
                errors++; $display("FAIL bp_fields_stable c%0d: got v %0h id %0h wdata %0h expected v 1 id 2 wdata %0h", c, rr_bus.mem_valid, rr_bus.mem_id, rr_bus.mem_wdata, wdata_of(2));
            end
            tick();
        end
        rr_bus.mem_ready = 1'b1;
        #1;
        checks++; if (rr_bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_grant: got %0h expected 1", rr_bus.req_ready); end
        rr_q.push_back(mk(0, 1'b0, 2'd0));
        e = rr_q.pop_front();
        checks++; if (rr_bus.mem_id !== e.id || rr_bus.mem_rnw !== e.rnw) begin errors++; $display("FAIL bp_drain_req: got id %0h expected %0h", rr_bus.mem_id, e.id); end
        tick();
        rr_bus.req_valid = '0;
        #1;
        e = rr_q.pop_front();
        checks++; if (rr_bus.mem_valid !== 1'b1 || rr_bus.mem_id !== e.id || rr_bus.mem_wdata !== e.wdata) begin
            errors++; $display("FAIL bp_no_bubble: got v %0h id %0h expected v 1 id %0h", rr_bus.mem_valid, rr_bus.mem_id, e.id);
        end
        tick();
    endtask

    task automatic test_fifo_full;
        rr_bus.mem_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rr_bus.req_valid  = FF_VALID[c];
            rr_bus.req_rnw    = FF_RNW[c];
            rr_bus.mem_rvalid = FF_RET[c];
            rr_bus.mem_rlast  = FF_RET[c];
            #1;
            checks++; if (rr_bus.req_ready !== onehot(FF_GNT[c])) begin errors++; $display("FAIL full_grant c%0d: got %0h expected %0h", c, rr_bus.req_ready, onehot(FF_GNT[c])); end
            checks++; if (rr_bus.rsp_valid !== (FF_RET[c] ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL full_rsp c%0d: got %0h expected %0h", c, rr_bus.rsp_valid, FF_RET[c] ? 4'b0001 : 4'b0000); end
            if (FF_GNT[c] >= 0) rr_q.push_back(mk(FF_GNT[c], FF_GNT[c] == 0, 2'd0));
            if (rr_bus.mem_valid) begin
                if (rr_q.size() == 0) begin
                    checks++; errors++; $display("FAIL full_unexpected_req: got id %0h expected none", rr_bus.mem_id);
                end else begin
                    e = rr_q.pop_front();
                    checks++; if (rr_bus.mem_id !== e.id || rr_bus.mem_rnw !== e.rnw) begin errors++; $display("FAIL full_mem_req: got id %0h rnw %0h expected id %0h rnw %0h", rr_bus.mem_id, rr_bus.mem_rnw, e.id, e.rnw); end
                end
            end
            tick();
        end
        for (int b = 0; b < 4; b++) begin
            rr_bus.mem_rvalid = 1'b1; rr_bus.mem_rlast = 1'b1;
            #1;
            checks++; if (rr_bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL full_drain_rsp b%0d: got %0h expected 1", b, rr_bus.rsp_valid); end
            tick();
        end
        rr_bus.mem_rvalid = 1'b0; rr_bus.mem_rlast = 1'b0;
    endtask

    task automatic test_burst_routing;
        rr_bus.mem_ready = 1'b1;
        rr_bus.req_len[3*LW +: LW] = 2'd3;
        rr_bus.req_valid = 4'b1000; rr_bus.req_rnw = 4'b1000;
        #1;
        checks++; if (rr_bus.req_ready !== 4'b1000) begin errors++; $display("FAIL burst_grant3: got %0h expected 8", rr_bus.req_ready); end
        rr_q.push_back(mk(3, 1'b1, 2'd3));
        tick();
        rr_bus.req_valid = 4'b0001; rr_bus.req_rnw = 4'b0001;
        #1;
        checks++; if (rr_bus.req_ready !== 4'b0001) begin errors++; $display("FAIL burst_grant0: got %0h expected 1", rr_bus.req_ready); end
        rr_q.push_back(mk(0, 1'b1, 2'd0));
        for (int c = 0; c < 2; c++) begin
            e = rr_q.pop_front();
            checks++; if (rr_bus.mem_id !== e.id || rr_bus.mem_len !== e.len) begin errors++; $display("FAIL burst_mem_req: got id %0h len %0h expected id %0h len %0h", rr_bus.mem_id, rr_bus.mem_len, e.id, e.len); end
            tick();
            rr_bus.req_valid = '0;
            #1;
        end
        rr_bus.req_len = '0;
        for (int b = 0; b < 5; b++) begin
            rr_bus.mem_rvalid = 1'b1;
            rr_bus.mem_rlast  = (b >= 3);
            rr_bus.mem_rdata  = 32'hB000_0000 + 32'(b);
            #1;
            checks++; if (rr_bus.rsp_valid !== ((b < 4) ? 4'b1000 : 4'b0001)) begin errors++; $display("FAIL burst_rsp b%0d: got %0h expected %0h", b, rr_bus.rsp_valid, (b < 4) ? 4'b1000 : 4'b0001); end
            checks++; if (rr_bus.rsp_data !== 32'hB000_0000 + 32'(b) || rr_bus.rsp_last !== (b >= 3)) begin errors++; $display("FAIL burst_data b%0d: got %0h last %0h expected %0h", b, rr_bus.rsp_data, rr_bus.rsp_last, 32'hB000_0000 + 32'(b)); end
            tick();
        end
        rr_bus.mem_rvalid = 1'b0; rr_bus.mem_rlast = 1'b0;
    endtask

    task automatic test_spurious_and_reset;
        rr_bus.mem_rvalid = 1'b1; rr_bus.mem_rlast = 1'b1;
        #1;
        checks++; if (rr_bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL spur_rsp: got %0h expected 0", rr_bus.rsp_valid); end
        tick();
        rr_bus.mem_rvalid = 1'b0; rr_bus.mem_rlast = 1'b0;
        tick(); tick();
        checks++; if (rr_bus.protocol_err !== 1'b1) begin errors++; $display("FAIL spur_sticky: got %0h expected 1", rr_bus.protocol_err); end
        rr_bus.mem_ready = 1'b1;
        rr_bus.req_valid = 4'b0110; rr_bus.req_rnw = 4'b0110;
        #1;
        checks++; if (rr_bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rst_grant1: got %0h expected 2", rr_bus.req_ready); end
        rr_q.push_back(mk(1, 1'b1, 2'd0));
        tick();
        rr_bus.req_valid = 4'b0100;
        #1;
        checks++; if (rr_bus.req_ready !== 4'b0100) begin errors++; $display("FAIL rst_grant2: got %0h expected 4", rr_bus.req_ready); end
        rr_q.push_back(mk(2, 1'b1, 2'd0));
        e = rr_q.pop_front();
        checks++; if (rr_bus.mem_id !== e.id) begin errors++; $display("FAIL rst_mem_req1: got %0h expected %0h", rr_bus.mem_id, e.id); end
        tick();
        rr_bus.req_valid = '0; rr_bus.mem_ready = 1'b0;
        #1;
        e = rr_q.pop_front();
        checks++; if (rr_bus.mem_valid !== 1'b1 || rr_bus.mem_id !== e.id) begin errors++; $display("FAIL rst_held_req: got v %0h id %0h expected v 1 id %0h", rr_bus.mem_valid, rr_bus.mem_id, e.id); end
        rst_n = 1'b0;
        rr_bus.req_valid = 4'hF; rr_bus.mem_rvalid = 1'b1; rr_bus.mem_rlast = 1'b1;
        #1;
        checks++; if (rr_bus.req_ready !== 4'b0 || rr_bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL rst_comb_outputs: got ready %0h rsp %0h expected 0 0", rr_bus.req_ready, rr_bus.rsp_valid); end
        tick();
        rst_n = 1'b1;
        rr_bus.req_valid = '0; rr_bus.mem_rvalid = 1'b0; rr_bus.mem_rlast = 1'b0;
        rr_q.delete();
        #1;
        checks++; if (rr_bus.mem_valid !== 1'b0 || rr_bus.protocol_err !== 1'b0 || rr_bus.mem_id !== 2'd0) begin
            errors++; $display("FAIL rst_state: got v %0h err %0h id %0h expected 0 0 0", rr_bus.mem_valid, rr_bus.protocol_err, rr_bus.mem_id);
        end
        rr_bus.mem_rvalid = 1'b1; rr_bus.mem_rlast = 1'b1;
        #1;
        checks++; if (rr_bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL rst_fifo_empty_rsp: got %0h expected 0", rr_bus.rsp_valid); end
        tick();
        rr_bus.mem_rvalid = 1'b0; rr_bus.mem_rlast = 1'b0;
        rr_bus.mem_ready = 1'b1; rr_bus.req_valid = 4'hF; rr_bus.req_rnw = '0;
        #1;
        checks++; if (rr_bus.protocol_err !== 1'b1) begin errors++; $display("FAIL rst_fifo_empty_err: got %0h expected 1", rr_bus.protocol_err); end
        checks++; if (rr_bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr_cleared: got %0h expected 1", rr_bus.req_ready); end
        tick();
        rr_bus.req_valid = '0;
        tick();
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_rr_fairness();
        test_fixed();
        test_back_pressure();
        test_fifo_full();
        test_burst_routing();
        test_spurious_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
